vend_seq_ctrl: RTL
==================

Name: vend_seq_ctrl

Overview:
Sequencing controller for the vending datapath. Accumulates coin credit, accepts a product selection, drives a dispense handshake to the product motor, then pays out change one 5rs coin at a time via a change-hopper handshake. Sits between the coin acceptor/keypad and the dispense/hopper actuators; replaces the single-product fixed-price flow with multi-product pricing, cancel/refund and fault recovery.

Parameters:
NUM_PROD, 4, number of products (sel_id width = $clog2(NUM_PROD))
CREDIT_W, 5, credit register width, units of 5rs
MAX_CREDIT, 12, maximum credit held (60rs); coins beyond this are rejected
TIMEOUT, 16, cycles to wait for disp_ack before declaring fault

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
coin  in  2  00 none, 01 5rs, 10 10rs, 11 invalid; one coin per cycle
coin_rej  out  1  one-cycle pulse: coin in previous cycle rejected
sel_valid  in  1  product selection strobe
sel_id  in  $clog2(NUM_PROD)  selected product
cancel  in  1  refund request
nsf  out  1  one-cycle pulse: selection refused (insufficient credit)
disp_req  out  1  dispense request, held until disp_ack
disp_id  out  $clog2(NUM_PROD)  product being dispensed, stable while disp_req
disp_ack  in  1  motor done
chg_req  out  1  request one 5rs coin from hopper
chg_ack  in  1  hopper released one coin
credit  out  CREDIT_W  current credit, 5rs units
busy  out  1  high in DISPENSE, CHANGE
err_fault  out  1  sticky dispense-timeout flag, cleared only by reset

Behaviour:
- Reset (rst low, async): state IDLE; credit 0; all outputs 0; held credit is lost by design.
- States: IDLE (credit==0), CREDIT, DISPENSE, CHANGE.
- IDLE/CREDIT coin: 01 adds 1, 10 adds 2, registered next edge; if sum > MAX_CREDIT or coin==11, credit unchanged and coin_rej pulses next cycle. IDLE->CREDIT on first accepted coin.
- Coins in DISPENSE/CHANGE always rejected (coin_rej pulse).
- CREDIT, sel_valid: if credit >= PRICE[sel_id], credit -= price, latch disp_id, -> DISPENSE, disp_req high next cycle. Else nsf pulses, stay CREDIT. sel_valid in IDLE: nsf pulse.
- Same-cycle priority in CREDIT: cancel > sel_valid > coin; lower-priority coin is rejected (coin_rej), lower-priority sel ignored without nsf.
- cancel in CREDIT -> CHANGE (full refund). cancel in IDLE/DISPENSE/CHANGE ignored.
- DISPENSE: disp_req held; wait counter starts at 0. On disp_ack: disp_req drops next cycle; -> CHANGE if credit>0 else IDLE. Counter reaching TIMEOUT with no ack: credit += price (restore), err_fault set, disp_req drops, -> CHANGE (refund all).
- CHANGE: chg_req high while credit>0; each cycle with chg_req & chg_ack decrements credit by 1. On the ack that makes credit 0: chg_req low next cycle, -> IDLE. chg_ack without chg_req ignored.
- disp_ack outside DISPENSE ignored.
- Latency: coin-to-credit 1 cycle; sel-to-disp_req 1 cycle; ack-to-deassert 1 cycle.
- err_fault does not block further vending.

Decomposition:
- Package vend_pkg: coin encoding constants (COIN_NONE/5/10/BAD), state enum vend_state_t, PRICE table in 5rs units {3,4,5,2} (15/20/25/10rs), shared with vending_machine.
- Sub-module vend_credit: credit register with add/subtract/restore, MAX_CREDIT saturation check, reject flag.

Test Plan:
- Reset, coins 01,10 -> credit 1 then 3; sel_id 0 -> disp_req=1, disp_id=0, credit 0; disp_ack -> IDLE, no chg_req.
- Coins 10,10,10 (credit 6), sel_id 1 (price 4) -> dispense, ack -> chg_req, two chg_acks -> credit 0, IDLE.
- Credit 2, sel_id 2 (price 5) -> nsf pulse, credit 2 unchanged; cancel -> 2 change coins paid.
- Credit 11, coin 10 -> coin_rej, credit 11; coin 11 in IDLE -> coin_rej; coin during DISPENSE -> coin_rej.
- Credit 4, sel_id 0, hold disp_ack low 16 cycles -> err_fault=1, credit restored to 4, 4 change coins, IDLE; err_fault stays 1.
- Mid-CHANGE (credit 3), rst low asynchronously -> all outputs 0 immediately, IDLE after release; cancel+sel same cycle -> refund, no dispense.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared definitions for the vending sequencer: coin codes, FSM states,
// default sizing and the product price table (in 5rs units).
package vend_pkg;

    localparam int DEF_NUM_PROD   = 4;
    localparam int DEF_CREDIT_W   = 5;
    localparam int DEF_MAX_CREDIT = 12;
    localparam int DEF_TIMEOUT    = 16;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_BAD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CREDIT,
        ST_DISPENSE,
        ST_CHANGE
    } vend_state_t;

    // Price of each product in 5rs units: 15, 20, 25 and 10 rupees.
    function automatic int unsigned price_of(input int unsigned id);
        case (id)
            0:       return 3;
            1:       return 4;
            2:       return 5;
            3:       return 2;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/vend_credit.sv
// Credit register: coin accumulation with saturation check, purchase
// subtract, timeout restore and one-unit change decrement.
module vend_credit
    import vend_pkg::*;
#(
    parameter int CREDIT_W   = DEF_CREDIT_W,
    parameter int MAX_CREDIT = DEF_MAX_CREDIT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          coin,
    input  logic                coin_en,
    input  logic                sub_en,
    input  logic                restore_en,
    input  logic [CREDIT_W-1:0] amt,
    input  logic                dec_en,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_ok,
    output logic                coin_rej
);

    logic [CREDIT_W:0]   coin_add;
    logic [CREDIT_W:0]   sum;
    logic [CREDIT_W-1:0] credit_next;
    logic                coin_legal;

    // Decode the coin value; the extra bit on sum exposes overflow past MAX_CREDIT.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        coin_add = '0;
        case (coin)
            COIN_5:  coin_add = (CREDIT_W+1)'(1);
            COIN_10: coin_add = (CREDIT_W+1)'(2);
            default: coin_add = '0;
        endcase
    end

    assign coin_legal = (coin == COIN_5) || (coin == COIN_10);
    assign sum        = {1'b0, credit} + coin_add;
    assign coin_ok    = coin_en && coin_legal && (sum <= (CREDIT_W+1)'(MAX_CREDIT));

    // Select the next credit value; the controller never asserts two updates at once.
    always_comb begin
        credit_next = credit;
        if (restore_en)
            credit_next = credit + amt;
        else if (sub_en)
            credit_next = credit - amt;
        else if (dec_en)
            credit_next = credit - CREDIT_W'(1);
        else if (coin_ok)
            credit_next = sum[CREDIT_W-1:0];
    end

    // Credit register and registered reject pulse for any coin not taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit   <= '0;
            coin_rej <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            credit   <= credit_next;
            coin_rej <= (coin != COIN_NONE) && !coin_ok;
        end
    end

endmodule

// File: rtl/vend_seq_ctrl.sv
// Vending sequencer: credit accumulation, product selection with pricing,
// dispense handshake with timeout fault, and coin-by-coin change payout.
module vend_seq_ctrl
    import vend_pkg::*;
#(
    parameter int NUM_PROD   = DEF_NUM_PROD,
    parameter int CREDIT_W   = DEF_CREDIT_W,
    parameter int MAX_CREDIT = DEF_MAX_CREDIT,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  coin,
    output logic                        coin_rej,
    input  logic                        sel_valid,
    input  logic [$clog2(NUM_PROD)-1:0] sel_id,
    input  logic                        cancel,
    output logic                        nsf,
    output logic                        disp_req,
    output logic [$clog2(NUM_PROD)-1:0] disp_id,
    input  logic                        disp_ack,
    output logic                        chg_req,
    input  logic                        chg_ack,
    output logic [CREDIT_W-1:0]         credit,
    output logic                        busy,
    output logic                        err_fault
);

    localparam int PROD_W = $clog2(NUM_PROD);
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    vend_state_t         state, state_next;
    logic [CNT_W-1:0]    wait_cnt;
    logic [PROD_W-1:0]   disp_id_q;
    logic                nsf_q;
    logic                err_q;

    logic [CREDIT_W-1:0] sel_price;
    logic [CREDIT_W-1:0] disp_price;
    logic                coin_en;
    logic                coin_ok;
    logic                sel_ok;
    logic                nsf_set;
    logic                timeout;
    logic                dec_en;

    assign sel_price  = CREDIT_W'(price_of(32'(sel_id)));
    assign disp_price = CREDIT_W'(price_of(32'(disp_id_q)));

    // In CREDIT, cancel beats selection and both beat a coin arriving that cycle.
    assign coin_en = (state == ST_IDLE) ||
                     ((state == ST_CREDIT) && !cancel && !sel_valid);
    assign sel_ok  = (state == ST_CREDIT) && !cancel && sel_valid &&
                     (credit >= sel_price);
    assign nsf_set = sel_valid && ((state == ST_IDLE) ||
                     ((state == ST_CREDIT) && !cancel && (credit < sel_price)));
    assign timeout = (state == ST_DISPENSE) && !disp_ack &&
                     (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign dec_en  = chg_req && chg_ack;

    vend_credit #(
        .CREDIT_W   (CREDIT_W),
        .MAX_CREDIT (MAX_CREDIT)
    ) u_credit (
        .clk        (clk),
        .rst        (rst),
        .coin       (coin),
        .coin_en    (coin_en),
        .sub_en     (sel_ok),
        .restore_en (timeout),
        .amt        (timeout ? disp_price : sel_price),
        .dec_en     (dec_en),
        .credit     (credit),
        .coin_ok    (coin_ok),
        .coin_rej   (coin_rej)
    );

    // State register plus the small datapath registers owned by the FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            disp_id_q <= '0;
            nsf_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state <= state_next;
            nsf_q <= nsf_set;
            if (sel_ok)
                disp_id_q <= sel_id;
            if (timeout)
                err_q <= 1'b1;
            if (state != ST_DISPENSE)
                wait_cnt <= '0;
            else if (!disp_ack)
                wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (coin_ok)
                    state_next = ST_CREDIT;
            end
            ST_CREDIT: begin
                if (cancel)
                    state_next = ST_CHANGE;
                else if (sel_ok)
                    state_next = ST_DISPENSE;
            end
            ST_DISPENSE: begin
                if (disp_ack)
                    state_next = (credit != '0) ? ST_CHANGE : ST_IDLE;
                else if (timeout)
                    state_next = ST_CHANGE;
            end
            ST_CHANGE: begin
                if ((credit == '0) || (dec_en && (credit == CREDIT_W'(1))))
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from registered state.
    always_comb begin
        disp_req  = (state == ST_DISPENSE);
        chg_req   = (state == ST_CHANGE) && (credit != '0);
        busy      = (state == ST_DISPENSE) || (state == ST_CHANGE);
        disp_id   = disp_id_q;
        nsf       = nsf_q;
        err_fault = err_q;
    end

endmodule
